// File: rtl/urvsoc_uart_pkg.sv
// Shared definitions for the urvsoc UART blocks: receiver state encoding,
// oversampling ratio and the baud divisor calculation.
package urvsoc_uart_pkg;

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_START = 3'd1;
    localparam logic [2:0] C_ST_DATA  = 3'd2;
    localparam logic [2:0] C_ST_STOP  = 3'd3;
    localparam logic [2:0] C_ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_START = C_ST_START,
        ST_DATA  = C_ST_DATA,
        ST_STOP  = C_ST_STOP,
        ST_BREAK = C_ST_BREAK
    } rx_state_t;

    localparam int c_os = 16;

    // Rounded clocks-per-tick so that c_os ticks span one bit period.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (c_os / 2) * baud) / (c_os * baud);
    endfunction

endpackage

// File: rtl/urvsoc_uart_rx_fifo.sv
// Small synchronous FIFO with power-of-two depth; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module urvsoc_uart_rx_fifo
    import urvsoc_uart_pkg::*;
#(
    parameter int g_width = 8,
    parameter int g_depth = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [g_width-1:0] data_i,
    output logic               full_o,
    input  logic               pop_i,
    output logic [g_width-1:0] data_o,
    output logic               empty_o
);

    localparam int C_AW = $clog2(g_depth);

    logic [g_width-1:0] mem_r [g_depth];
    logic [C_AW:0]      wr_ptr_r;
    logic [C_AW:0]      rd_ptr_r;
    logic               do_push_s;
    logic               do_pop_s;

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign empty_o   = (wr_ptr_r == rd_ptr_r);
    assign full_o    = (wr_ptr_r[C_AW] != rd_ptr_r[C_AW]) &&
                       (wr_ptr_r[C_AW-1:0] == rd_ptr_r[C_AW-1:0]);
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign data_o    = mem_r[rd_ptr_r[C_AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < g_depth; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[C_AW-1:0]] <= data_i;
                wr_ptr_r                  <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/urvsoc_uart_rx.sv
// UART receiver: 16x oversampled line decoder feeding a byte FIFO with a
// valid/ready consumer interface and framing/overrun error pulses.
module urvsoc_uart_rx
    import urvsoc_uart_pkg::*;
#(
    parameter int g_clk_freq   = 100000000,
    parameter int g_baud       = 115200,
    parameter int g_fifo_depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int                   C_DIV     = calc_div(g_clk_freq, g_baud);
    localparam int                   C_DIV_W   = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_DIV_W-1:0]   C_DIV_MAX = C_DIV_W'(C_DIV - 1);

    logic               rxd_meta_r;
    logic               rxd_sync_r;
    logic               rxd_s;
    rx_state_t          state_r;
    logic [C_DIV_W-1:0] div_cnt_r;
    logic [3:0]         os_cnt_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               frame_err_r;
    logic               overrun_r;
    logic               tick_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Two-flop synchronizer; idle-high reset keeps reset from looking like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd_i;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    assign rxd_s  = rxd_sync_r;
    assign tick_s = (div_cnt_r == C_DIV_MAX);
    assign push_s = (state_r == ST_STOP) && tick_s && (os_cnt_r == 4'd15) && rxd_s;
    assign pop_s  = rx_ready_i & ~fifo_empty_s;

    // Tick generator, frame FSM and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= '0;
            os_cnt_r    <= 4'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= push_s & fifo_full_s & ~pop_s;

            // Restarting the divisor at the start edge phase-aligns every sample to it.
            if ((state_r == ST_IDLE) && !rxd_s) begin
                div_cnt_r <= '0;
            end else if (tick_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + C_DIV_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_r  <= ST_START;
                        os_cnt_r <= 4'd0;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (os_cnt_r == 4'd7) begin
                            if (rxd_s) begin
                                state_r <= ST_IDLE;
                            end else begin
                                state_r   <= ST_DATA;
                                os_cnt_r  <= 4'd0;
                                bit_cnt_r <= 3'd0;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                        if (os_cnt_r == 4'd15) begin
                            shift_r   <= {rxd_s, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                        if (os_cnt_r == 4'd15) begin
                            if (rxd_s) begin
                                state_r <= ST_IDLE;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before another frame can start.
                    if (rxd_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    urvsoc_uart_rx_fifo #(
        .g_width (8),
        .g_depth (g_fifo_depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (shift_r),
        .full_o  (fifo_full_s),
        .pop_i   (pop_s),
        .data_o  (rx_data_o),
        .empty_o (fifo_empty_s)
    );

    assign rx_valid_o  = ~fifo_empty_s;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule
